// File: rtl/j68_dec_arbiter_if.sv
// Request/response channels between the two decode requesters and the arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface j68_dec_arbiter_if;
    logic        req0_valid;
    logic [7:0]  req0_addr;
    logic        req0_ready;
    logic        rsp0_valid;
    logic [35:0] rsp0_data;
    logic        rsp0_ready;

    logic        req1_valid;
    logic [7:0]  req1_addr;
    logic        req1_ready;
    logic        rsp1_valid;
    logic [35:0] rsp1_data;
    logic        rsp1_ready;

    modport master (
        output req0_valid, req0_addr, rsp0_ready,
        output req1_valid, req1_addr, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_data,
        input  req1_ready, rsp1_valid, rsp1_data
    );

    modport slave (
        input  req0_valid, req0_addr, rsp0_ready,
        input  req1_valid, req1_addr, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_data,
        output req1_ready, rsp1_valid, rsp1_data
    );
endinterface

// File: rtl/j68_dec_arbiter.sv
// Two-port arbiter in front of the 256x36 decode ROM: one transaction in flight,
// CPU port favoured, debug port promoted after STARVE_LIMIT consecutive losses.
module j68_dec_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clock,
    input  logic               reset,
    j68_dec_arbiter_if.slave   bus,
    output logic [7:0]         rom_address,
    input  logic [35:0]        rom_q
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]  state;
    logic        gnt_id;
    logic [7:0]  addr_q;
    logic [35:0] data_q;
    logic [3:0]  starve_cnt;

    logic        pick1;
    logic        take;
    logic [7:0]  win_addr;

    always_comb begin
        pick1    = bus.req1_valid && (!bus.req0_valid || starve_cnt >= LIMIT);
        // Gated by reset so ready and the ROM address read 0 while reset is held.
        take     = (state == IDLE) && !reset && (bus.req0_valid || bus.req1_valid);
        win_addr = pick1 ? bus.req1_addr : bus.req0_addr;
    end

    assign bus.req0_ready = take && !pick1;
    assign bus.req1_ready = take && pick1;
    assign rom_address    = take ? win_addr : addr_q;

    assign bus.rsp0_valid = (state == RESP) && !gnt_id;
    assign bus.rsp1_valid = (state == RESP) && gnt_id;
    assign bus.rsp0_data  = bus.rsp0_valid ? data_q : 36'd0;
    assign bus.rsp1_data  = bus.rsp1_valid ? data_q : 36'd0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gnt_id     <= 1'b0;
            addr_q     <= 8'd0;
            data_q     <= 36'd0;
            starve_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        gnt_id <= pick1;
                        addr_q <= win_addr;
                        state  <= WAIT;
                    end
                    // A debug request that is not picked here has lost to port 0.
                    if (pick1 || !bus.req1_valid)
                        starve_cnt <= 4'd0;
                    else if (starve_cnt != 4'hF)
                        starve_cnt <= starve_cnt + 4'd1;
                end
                WAIT: begin
                    data_q <= rom_q;
                    state  <= RESP;
                end
                RESP: begin
                    if (gnt_id ? bus.rsp1_ready : bus.rsp0_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/j68_dec_arbiter.md
J68_DEC_ARBITER -- requirements
Module: j68_dec_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: number of consecutive port-0 grants that port 1 may lose while requesting before it is given priority (legal range 1..15).
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have ports req0_valid (input, 1), req0_addr (input, 8) and req0_ready (output, 1): CPU decode request channel for one decode ROM entry.
REQ-005 SHALL have ports rsp0_valid (output, 1), rsp0_data (output, 36) and rsp0_ready (input, 1): CPU decode response channel.
REQ-006 SHALL have ports req1_valid (input, 1), req1_addr (input, 8) and req1_ready (output, 1): debug/readback request channel.
REQ-007 SHALL have ports rsp1_valid (output, 1), rsp1_data (output, 36) and rsp1_ready (input, 1): debug response channel.
REQ-008 SHALL have port rom_address, output, 8: address to the 256x36 decode ROM.
REQ-009 SHALL have port rom_q, input, 36: ROM data, valid one clock after rom_address is sampled.

Function
REQ-010 SHALL implement the FSM states IDLE, WAIT and RESP, with exactly one transaction outstanding at a time.
REQ-011 In IDLE SHALL grant a requester: port 1 wins if only req1_valid is high, or if both are valid and starve_cnt is at least STARVE_LIMIT; otherwise port 0 wins.
REQ-012 In IDLE with a winner, SHALL assert only the winner's reqN_ready in that cycle (combinational), drive rom_address equal to the winner's addr, latch the grant id and addr, and go to WAIT.
REQ-013 req0_ready and req1_ready SHALL be 0 in WAIT and RESP, and 0 in IDLE when there is no request.
REQ-014 In WAIT and RESP, rom_address SHALL equal the latched addr; in IDLE with no request it SHALL hold its last value.
REQ-015 In WAIT SHALL register rom_q into the 36-bit data register and go to RESP unconditionally.
REQ-016 In RESP SHALL assert rspN_valid for the granted port only, and drive rspN_data with the data register.
REQ-017 In RESP SHALL hold rspN_valid and rspN_data stable until rspN_ready is high, then return to IDLE on that edge.
REQ-018 Latency SHALL be rspN_valid high at the second rising edge after acceptance; peak throughput is 1 transaction per 3 cycles.
REQ-019 The rsp data of the non-granted port SHALL read 0, and its rsp valid SHALL stay 0.
REQ-020 starve_cnt (4 bits) SHALL behave as follows:
- clear to 0 on a port-1 grant, or when req1_valid is low in IDLE;
- increment on a port-0 grant while req1_valid is high;
- saturate at 15.
REQ-021 rspN_ready while the corresponding rspN_valid is 0 SHALL be ignored.
REQ-022 Requests arriving while not in IDLE SHALL be held off via ready=0; requesters keep valid and addr stable until ready.
REQ-023 A new request SHALL not be accepted in the same cycle as a RESP handshake; acceptance happens in the following IDLE cycle.

Reset
REQ-024 While reset is high SHALL force:
- state IDLE;
- req0_ready, req1_ready, rsp0_valid and rsp1_valid all 0;
- rsp0_data, rsp1_data, data register, latched addr and rom_address all 0;
- starve_cnt 0.
REQ-025 Reset asserted during WAIT or RESP SHALL discard the transaction with no response, and SHALL restart at IDLE on the first edge after deassertion.

Verification
REQ-026 Port-0 read: req0 addr 0x2A, ROM entry 0x2A = 36'h123456789, rsp0_ready=1 → req0_ready pulse in cycle 0, rsp0_valid in cycle 2 with data 36'h123456789, back in IDLE in cycle 3.
REQ-027 Response backpressure: rsp1_ready held low 5 cycles after rsp1_valid rises → rsp1_valid and rsp1_data stable for all 5 cycles, no new grant; completes on the rsp1_ready=1 edge.
REQ-028 Simultaneous requests: both ports continuously valid, STARVE_LIMIT=4 → grant sequence 0,0,0,0,1,0,0,0,0,1, and starve_cnt reads 0 after each port-1 grant.
REQ-029 Boundary addresses: reads of 0x00 and 0xFF return the matching ROM entries, and rom_address holds 0xFF through WAIT and RESP.
REQ-030 Mid-operation reset: reset pulse in WAIT → no rsp valid ever asserted for that request, all outputs 0 during reset, and the next request completes normally.
REQ-031 Idle hold: no requests for 10 cycles after a read of 0x55 → rom_address stays 0x55 and both ready and both valid stay 0.
